// File: rtl/pcihellocore_inport_edge.sv
// pcihellocore_inport_edge: Avalon-MM input port with a synchroniser,
// per-bit edge capture (write-1-to-clear) and a maskable interrupt.
// Register map: 0 data (RO), 1 reserved, 2 irqmask (RW), 3 edgecapture (W1C).
module pcihellocore_inport_edge #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0,
    parameter int IRQ_TYPE    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] prev;
    logic [DATA_WIDTH-1:0] irqmask;
    logic [DATA_WIDTH-1:0] edgecapture;
    logic [DATA_WIDTH-1:0] edge_det;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] clear_bits;
    logic [31:0]           read_mux;
    logic                  mask_we;
    logic                  capture_we;
    logic                  writedata_unused;

    // Per-bit edge selection between the current and previous synchronised value.
    function automatic logic [DATA_WIDTH-1:0] edge_select(
        input logic [DATA_WIDTH-1:0] cur,
        input logic [DATA_WIDTH-1:0] old
    );
        case (EDGE_TYPE)
            0:       return cur & ~old;
            1:       return ~cur & old;
            default: return cur ^ old;
        endcase
    endfunction

    assign data       = sync_q[SYNC_STAGES-1];
    assign wdata      = writedata[DATA_WIDTH-1:0];
    assign mask_we    = chipselect & write & (address == 2'd2);
    assign capture_we = chipselect & write & (address == 2'd3);
    assign clear_bits = capture_we ? wdata : '0;
    assign edge_det   = edge_select(data, prev);

    // Bits of writedata above the port width carry no meaning.
    assign writedata_unused = ^writedata;

    // Synchroniser chain for the asynchronous inputs, plus the one-cycle-old copy for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev <= data;
        end
    end

    // Interrupt mask register.
    always_ff @(posedge clk) begin
        if (reset) begin
            irqmask <= '0;
        end else if (mask_we) begin
            irqmask <= wdata;
        end
    end

    // Edge capture: a fresh edge overrides a simultaneous write-1-to-clear of the same bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            edgecapture <= '0;
        end else begin
            edgecapture <= (edgecapture & ~clear_bits) | edge_det;
        end
    end

    // Register select for the read path, zero-extended to the bus width.
    always_comb begin
        read_mux = '0;
        case (address)
            2'd0:    read_mux = 32'(data);
            2'd2:    read_mux = 32'(irqmask);
            2'd3:    read_mux = 32'(edgecapture);
            default: read_mux = '0;
        endcase
    end

    // Registered read data, refreshed every cycle with no read strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= read_mux;
        end
    end

    // Interrupt request from registered state only: either the masked data level or masked captured edges.
    always_comb begin
        if (IRQ_TYPE == 0) begin
            irq = |(data & irqmask);
        end else begin
            irq = |(edgecapture & irqmask);
        end
    end

endmodule

// File: doc/pcihellocore_inport_edge.md
# pcihellocore_inport_edge

Parametrised Avalon-MM input port: the next generation of the core's 16-bit read-only input PIO. Adds configurable width, a metastability synchroniser, per-bit edge capture with write-1-to-clear, and a maskable interrupt request. Sits on the PCI-to-Avalon bridge as an `s1` slave. Drives `irq` to the bridge's interrupt input.

## Interface
- `DATA_WIDTH`, 16 — width of `in_port`; legal range 1..32.
- `SYNC_STAGES`, 2 — flip-flop stages on `in_port` before any use; legal range 2..4.
- `EDGE_TYPE`, 0 — capture on: 0 rising, 1 falling, 2 any edge.
- `IRQ_TYPE`, 1 — interrupt source: 0 level, `|(data & mask)`; 1 edge, `|(edgecapture & mask)`.

- `clk`  in  1  — single clock for all logic.
- `reset`  in  1  — synchronous, active-high; clears all state on the `clk` edge where it is sampled high.
- `address`  in  2  — register select.
- `chipselect`  in  1  — qualifies `write`.
- `write`  in  1  — write strobe; effective only with `chipselect`=1.
- `writedata`  in  32  — write data; bits above `DATA_WIDTH`-1 are ignored.
- `in_port`  in  `DATA_WIDTH`  — asynchronous external inputs.
- `readdata`  out  32  — registered read data, zero-extended.
- `irq`  out  1  — interrupt request, active-high, level.

## Operation
- Register map, by `address`:
  - 0 — data, RO: synchronised `in_port`.
  - 1 — reserved: reads 0, writes ignored.
  - 2 — irqmask, RW.
  - 3 — edgecapture, R/W1C.
- Synchroniser: chain `s[0..SYNC_STAGES-1]`, with `s[0]` <= `in_port`. `data` = last stage.
- Edge detect:
  - `prev` <= `data` every cycle.
  - Per-bit rise = `data & ~prev`; fall = `~data & prev`; selected by `EDGE_TYPE`.
- Edge capture:
  - A detected edge sets the bit at the next edge.
  - A bit stays set until cleared by a write to address 3 with the corresponding `writedata` bit = 1.
  - Writing 0 to a bit leaves it unchanged.
  - Simultaneous edge and clear on the same bit: set wins; the bit remains 1.
- irqmask: on the edge where `chipselect`&`write`&`address`==2, irqmask <= `writedata[DATA_WIDTH-1:0]`.
- Writes to addresses 0 and 1 have no effect.
- `readdata`: every cycle, no read strobe, `readdata` <= zero-extended mux(`address`). Reads have no side effects.
- `irq`: combinational from the irqmask, edgecapture and `data` registers only. There is no combinational path from `in_port`, `address` or `writedata`.
- Reset values: all sync stages, `prev`, irqmask and edgecapture = 0; `readdata` = 0; `irq` = 0.
- Because `prev` is cleared, an input held high through reset registers a rising edge `SYNC_STAGES`+1 cycles after reset deasserts. This is intended.

## Timing
- Let `in_port` change before edge E1, with N = `SYNC_STAGES`:
  - `data` updates at E_N.
  - `readdata`(addr 0) shows the new value after E_{N+1}.
  - edgecapture bit sets at E_{N+1}.
  - `irq` (edge type, mask set) rises after E_{N+1}.
  - edgecapture is readable on `readdata` after E_{N+2}.
- Read latency is 1: `readdata` after edge k reflects `address` and register contents sampled at edge k.
- Write takes effect at the sampling edge. A read of the same register at the next edge returns the new value.
- Clearing the last masked edgecapture bit: `irq` falls after the write edge.
- Pulses shorter than one `clk` period may be missed. Pulses of ≥1 period are always captured.
- `reset` asserted mid-operation: all state is cleared at that edge regardless of `write` or edges. Pending edges are lost.

## Test plan
- Reset: hold `reset` 3 cycles with `in_port`=16'hFFFF.
  - During and immediately after reset: `readdata`=0, `irq`=0.
  - After 3 cycles: addr 0 reads 32'h0000FFFF.
  - addr 3 reads 32'h0000FFFF, since power-up rising edges are captured.
- Data path: set `in_port`=16'hA5C3 with `address`=0 → `readdata`=32'h0000A5C3 exactly 3 edges later, never earlier. Address 1 always reads 0.
- Edge + IRQ (`EDGE_TYPE`=0, `IRQ_TYPE`=1):
  - Write mask 16'h0010 to addr 2, then pulse `in_port[4]` high for 1 cycle → `irq`=1 after edge N+1; addr 3 reads 32'h00000010.
  - Pulse `in_port[5]` instead → bit 5 captured, `irq` stays 0.
- W1C: with edgecapture=16'h0030, write 32'h00000010 to addr 3 → edgecapture=16'h0020 and `irq`=0.
  - Repeat the write on the same edge as a new bit-4 rising edge → bit 4 stays 1 and `irq` stays 1.
- Level mode (`IRQ_TYPE`=0), with `EDGE_TYPE`=1 and `EDGE_TYPE`=2:
  - With mask 16'h0001, `irq` follows `data[0]`.
  - Falling edge on bit 0 sets edgecapture bit 0 only for `EDGE_TYPE`=1 or 2.
- Width/reset corner: `DATA_WIDTH`=32, `SYNC_STAGES`=4 → write 32'hFFFFFFFF to mask, read back 32'hFFFFFFFF. Assert `reset` mid-write → mask=0.
